dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL be the data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL be the byte-address width.
REQ-003 Derived MASK_SIZE SHALL be DATA_WIDTH/8 byte-enables per word and SHALL NOT be overridable.
REQ-004 clk  in  1  SHALL be the clock; all state updates on the rising edge.
REQ-005 arst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 req_valid  in  2  SHALL carry the per-port request valid; bit 0 is core LSU, bit 1 is DMA/debug.
REQ-007 req_ready  out  2  SHALL carry the per-port request accept.
REQ-008 req_we  in  2  SHALL carry the per-port write flag (1 = store, 0 = load).
REQ-009 req_mask  in  2*MASK_SIZE  SHALL carry the per-port byte-enables; port p uses slice [p*MASK_SIZE +: MASK_SIZE].
REQ-010 req_addr  in  2*ADDR_WIDTH  SHALL carry the per-port byte addresses, sliced as in REQ-009.
REQ-011 req_wdata  in  2*DATA_WIDTH  SHALL carry the per-port write data, sliced as in REQ-009.
REQ-012 rsp_valid  out  2  SHALL carry the per-port one-cycle response strobe.
REQ-013 rsp_rdata  out  DATA_WIDTH  SHALL carry the response data, shared by both ports and qualified by rsp_valid.
REQ-014 mem_write_en  out  1  SHALL drive the data-memory write enable.
REQ-015 mem_mask  out  MASK_SIZE  SHALL drive the data-memory byte-enables.
REQ-016 mem_addr  out  ADDR_WIDTH  SHALL drive the data-memory byte address.
REQ-017 mem_wdata  out  DATA_WIDTH  SHALL drive the data-memory write data.
REQ-018 mem_rdata  in  DATA_WIDTH  SHALL be the combinational data-memory read data for mem_addr.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-020 In IDLE with any req_valid bit set, the arbiter SHALL assert req_ready on exactly one granted port and SHALL move to ACCESS on that edge.
REQ-021 Arbitration SHALL be round-robin: with both ports valid, the grant goes to the port not named in last_grant; with one port valid, that port is granted.
REQ-022 last_grant SHALL update to the granted port on every accepted handshake.
REQ-023 req_ready SHALL be combinational from state, req_valid and last_grant; both bits SHALL be 0 outside IDLE.
REQ-024 On handshake, the arbiter SHALL register the granted port's we, mask, addr, wdata and port index.
REQ-025 In ACCESS, mem_addr, mem_mask and mem_wdata SHALL equal the registered values.
REQ-026 In ACCESS, mem_write_en SHALL equal the registered we.
REQ-027 In ACCESS, a load SHALL capture mem_rdata into the response register and a store SHALL load 0 into it.
REQ-028 At the end of ACCESS the FSM SHALL move to RESP.
REQ-029 In RESP, rsp_valid SHALL be asserted for exactly one cycle on the registered port only, with rsp_rdata driven from the response register.
REQ-030 The FSM SHALL return from RESP to IDLE unconditionally.
REQ-031 Timing: handshake at cycle N, memory access at N+1, rsp_valid at N+2; the next handshake is possible at N+3, for a peak throughput of one transaction per 3 cycles.
REQ-032 Outside ACCESS, mem_write_en, mem_mask, mem_addr and mem_wdata SHALL all be 0.
REQ-033 Outside RESP, rsp_valid SHALL be 0 and rsp_rdata SHALL hold its last value.
REQ-034 A store with mask 0 SHALL still be sequenced and SHALL still produce rsp_valid.
REQ-035 mem_addr SHALL pass the address unmodified, with no alignment checks and the low bits preserved.
REQ-036 Requests deasserted while not ready SHALL be dropped silently, and requesters SHALL hold valid and payload until ready.
REQ-037 Both ports requesting in the same cycle as a RESP-to-IDLE transition SHALL be arbitrated in the following IDLE cycle.

Reset
REQ-038 On arst_n low, asynchronously: state SHALL become IDLE and last_grant SHALL become 1, so that port 0 wins the first contention.
REQ-039 On arst_n low, all registered payload and response data SHALL clear to 0.
REQ-040 During reset, all outputs SHALL be 0.
REQ-041 Reset asserted during ACCESS SHALL suppress mem_write_en immediately, so no partial write occurs.
REQ-042 Reset asserted during RESP SHALL clear rsp_valid immediately, and the aborted transaction SHALL NOT be replayed.
REQ-043 After arst_n deasserts, the first handshake SHALL be possible on the first rising edge in IDLE.

Verification
REQ-044 Port 0 store: addr 0x100, wdata 0xDEADBEEF, mask 0xF -> req_ready[0]=1 at N; at N+1 mem_write_en=1 and mem_addr=0x100; at N+2 rsp_valid=01 and rsp_rdata=0.
REQ-045 Port 1 load: addr 0x100, mem model returns 0xDEADBEEF -> at N+2 rsp_valid=10 and rsp_rdata=0xDEADBEEF; mem_write_en stays 0 throughout.
REQ-046 Both ports held valid for 12 cycles after reset -> grants alternate 0,1,0,1 with one handshake every 3 cycles, and no rsp_valid bit is set in a non-RESP cycle.
REQ-047 Byte store: mask 0x4, wdata 0x00AB0000 at addr 0x204 -> mem_mask=0x4 in ACCESS only, and all mem_* outputs are 0 in IDLE and RESP.
REQ-048 arst_n pulsed low mid-ACCESS of a store -> mem_write_en drops the same cycle and no rsp_valid follows; the next request completes normally with 2-cycle latency.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Request/response and data-memory bus shared by the two requesters and the
// data-memory arbiter.
interface dmem_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   localparam int MASK_SIZE = DATA_WIDTH / 8;

   logic [1:0]              req_valid;
   logic [1:0]              req_ready;
   logic [1:0]              req_we;
   logic [2*MASK_SIZE-1:0]  req_mask;
   logic [2*ADDR_WIDTH-1:0] req_addr;
   logic [2*DATA_WIDTH-1:0] req_wdata;
   logic [1:0]              rsp_valid;
   logic [DATA_WIDTH-1:0]   rsp_rdata;
   logic                    mem_write_en;
   logic [MASK_SIZE-1:0]    mem_mask;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic [DATA_WIDTH-1:0]   mem_rdata;

   // Master is the environment: both requesters plus the memory returning rdata.
   modport master (
      output req_valid, req_we, req_mask, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata,
             mem_write_en, mem_mask, mem_addr, mem_wdata
   );

   modport slave (
      input  req_valid, req_we, req_mask, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata,
             mem_write_en, mem_mask, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single data memory; each
// transaction takes IDLE -> ACCESS -> RESP, one per three cycles at best.
module dmem_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic          clk,
   input  logic          arst_n,
   dmem_arbiter_if.slave bus
);
   localparam int MASK_SIZE = DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   state_e                  state_q;
   logic                    last_grant_q;
   logic                    port_q;
   logic                    we_q;
   logic [MASK_SIZE-1:0]    mask_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH-1:0]   rdata_q;

   logic [1:0]              grant;
   logic                    gport;

   // Gated by arst_n so req_ready stays low while reset is held.
   always_comb begin
      grant = '0;
      if (state_q == IDLE && arst_n) begin
         if (bus.req_valid == 2'b11) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
         end else begin
            grant = bus.req_valid;
         end
      end
   end

   assign gport         = grant[1];
   assign bus.req_ready = grant;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         port_q       <= 1'b0;
         we_q         <= 1'b0;
         mask_q       <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|grant) begin
                  last_grant_q <= gport;
                  port_q       <= gport;
                  we_q         <= gport ? bus.req_we[1] : bus.req_we[0];
                  mask_q       <= gport ? bus.req_mask[MASK_SIZE +: MASK_SIZE]
                                        : bus.req_mask[0 +: MASK_SIZE];
                  addr_q       <= gport ? bus.req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                                        : bus.req_addr[0 +: ADDR_WIDTH];
                  wdata_q      <= gport ? bus.req_wdata[DATA_WIDTH +: DATA_WIDTH]
                                        : bus.req_wdata[0 +: DATA_WIDTH];
                  state_q      <= ACCESS;
               end
            end
            ACCESS: begin
               rdata_q <= we_q ? '0 : bus.mem_rdata;
               state_q <= RESP;
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Memory bus is driven only in ACCESS; an async reset there kills the write at once.
   always_comb begin
      bus.mem_write_en = 1'b0;
      bus.mem_mask     = '0;
      bus.mem_addr     = '0;
      bus.mem_wdata    = '0;
      if (state_q == ACCESS) begin
         bus.mem_write_en = we_q;
         bus.mem_mask     = mask_q;
         bus.mem_addr     = addr_q;
         bus.mem_wdata    = wdata_q;
      end
   end

   assign bus.rsp_valid = (state_q == RESP) ? (port_q ? 2'b10 : 2'b01) : 2'b00;
   assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: single transactions on each port, byte and
// empty-mask stores, round-robin contention, and reset aborts in ACCESS/RESP.
module tb_dmem_arbiter;
   logic clk;
   logic arst_n;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   dmem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) u_dut (
      .clk    (clk),
      .arst_n (arst_n),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word-addressed memory model, byte-masked writes on the rising edge.
   logic [31:0] mem [256] = '{default: '0};
   always @(posedge clk) begin
      if (bus.mem_write_en) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.mem_mask[b]) mem[bus.mem_addr[9:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
         end
      end
   end
   assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int unsigned port, input logic we, input logic [3:0] mask,
                          input logic [31:0] addr, input logic [31:0] wdata);
      bus.req_valid = (port == 1) ? 2'b10 : 2'b01;
      bus.req_we    = {we, we};
      bus.req_mask  = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      if (port == 1) begin
         bus.req_mask[7:4]   = mask;
         bus.req_addr[63:32] = addr;
         bus.req_wdata[63:32] = wdata;
      end else begin
         bus.req_mask[3:0]   = mask;
         bus.req_addr[31:0]  = addr;
         bus.req_wdata[31:0] = wdata;
      end
   endtask

   // Entered just after a falling edge with the DUT idle; leaves it idle again.
   task automatic xact(input string tag, input int unsigned port, input logic we,
                       input logic [3:0] mask, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd);
      logic [1:0] oh;
      oh = (port == 1) ? 2'b10 : 2'b01;
      set_req(port, we, mask, addr, wdata);
      #1 check_val({tag, ".ready"}, bus.req_ready, oh);
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      check_val({tag, ".acc_we"},    bus.mem_write_en, we);
      check_val({tag, ".acc_addr"},  bus.mem_addr, addr);
      check_val({tag, ".acc_mask"},  bus.mem_mask, mask);
      check_val({tag, ".acc_wdata"}, bus.mem_wdata, wdata);
      check_val({tag, ".acc_rdy"},   bus.req_ready, 2'b00);
      check_val({tag, ".acc_rspv"},  bus.rsp_valid, 2'b00);
      @(negedge clk);
      #1;
      check_val({tag, ".rsp_valid"}, bus.rsp_valid, oh);
      check_val({tag, ".rsp_rdata"}, bus.rsp_rdata, exp_rd);
      check_val({tag, ".rsp_we"},    bus.mem_write_en, 1'b0);
      check_val({tag, ".rsp_addr"},  bus.mem_addr, 32'h0);
      check_val({tag, ".rsp_mask"},  bus.mem_mask, 4'h0);
      check_val({tag, ".rsp_wdata"}, bus.mem_wdata, 32'h0);
      @(negedge clk);
      #1;
      check_val({tag, ".idle_rspv"}, bus.rsp_valid, 2'b00);
      check_val({tag, ".hold_rd"},   bus.rsp_rdata, exp_rd);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      arst_n        = 1'b0;
      bus.req_valid = 2'b11;
      bus.req_we    = 2'b11;
      bus.req_mask  = 8'hFF;
      bus.req_addr  = {32'h0000_0010, 32'h0000_0020};
      bus.req_wdata = {32'h1111_1111, 32'h2222_2222};
      #1;
      check_val("rst.ready", bus.req_ready, 2'b00);
      check_val("rst.rspv",  bus.rsp_valid, 2'b00);
      check_val("rst.rdata", bus.rsp_rdata, 32'h0);
      check_val("rst.we",    bus.mem_write_en, 1'b0);
      check_val("rst.addr",  bus.mem_addr, 32'h0);
      @(negedge clk);
      @(negedge clk);
      bus.req_valid = '0;
      arst_n        = 1'b1;

      // First edge after reset release accepts the store.
      xact("st0",   0, 1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0);
      xact("ld1",   1, 1'b0, 4'hF, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF);
      xact("bst0",  0, 1'b1, 4'h4, 32'h0000_0204, 32'h00AB_0000, 32'h0);
      xact("ld1b",  1, 1'b0, 4'hF, 32'h0000_0204, 32'h0,         32'h00AB_0000);
      xact("m0st1", 1, 1'b1, 4'h0, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0);
      xact("ld0u",  0, 1'b0, 4'hF, 32'h0000_0103, 32'h0,         32'hDEAD_BEEF);

      // Reset in the middle of a store's ACCESS cycle.
      set_req(0, 1'b1, 4'hF, 32'h0000_0300, 32'h1234_5678);
      #1 check_val("ra.ready", bus.req_ready, 2'b01);
      @(negedge clk);
      bus.req_valid = '0;
      #1 check_val("ra.acc_we", bus.mem_write_en, 1'b1);
      #1 arst_n = 1'b0;
      #1;
      check_val("ra.we_drop", bus.mem_write_en, 1'b0);
      check_val("ra.addr0",   bus.mem_addr, 32'h0);
      check_val("ra.rdata0",  bus.rsp_rdata, 32'h0);
      #1 arst_n = 1'b1;
      @(negedge clk);
      #1;
      check_val("ra.no_rsp",  bus.rsp_valid, 2'b00);
      check_val("ra.no_wr",   mem[192], 32'h0);
      @(negedge clk);
      #1 check_val("ra.no_rsp2", bus.rsp_valid, 2'b00);
      xact("post", 1, 1'b0, 4'hF, 32'h0000_0204, 32'h0, 32'h00AB_0000);

      // Fresh reset, then both ports contend continuously.
      arst_n = 1'b0;
      #1 arst_n = 1'b1;
      @(negedge clk);
      bus.req_valid = 2'b11;
      bus.req_we    = 2'b00;
      bus.req_mask  = 8'hFF;
      bus.req_addr  = {32'h0000_0204, 32'h0000_0100};
      bus.req_wdata = '0;
      for (int k = 0; k < 12; k++) begin
         logic [1:0]  exp_rdy;
         logic [1:0]  exp_rsp;
         logic [1:0]  oh;
         oh      = ((k / 3) % 2 == 1) ? 2'b10 : 2'b01;
         exp_rdy = (k % 3 == 0) ? oh : 2'b00;
         exp_rsp = (k % 3 == 2) ? oh : 2'b00;
         #1;
         check_val($sformatf("rr%0d.ready", k), bus.req_ready, exp_rdy);
         check_val($sformatf("rr%0d.rspv", k),  bus.rsp_valid, exp_rsp);
         if (k % 3 == 2)
            check_val($sformatf("rr%0d.rdata", k), bus.rsp_rdata,
                      (oh == 2'b10) ? 32'h00AB_0000 : 32'hDEAD_BEEF);
         @(negedge clk);
      end
      bus.req_valid = '0;

      // Reset during RESP drops the strobe and nothing is replayed.
      set_req(0, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
      #1 check_val("rr.ready", bus.req_ready, 2'b01);
      @(negedge clk);
      bus.req_valid = '0;
      @(negedge clk);
      #1 check_val("rr.rspv", bus.rsp_valid, 2'b01);
      #1 arst_n = 1'b0;
      #1;
      check_val("rr.rspv_drop", bus.rsp_valid, 2'b00);
      check_val("rr.rdata_clr", bus.rsp_rdata, 32'h0);
      #1 arst_n = 1'b1;
      @(negedge clk);
      #1;
      check_val("rr.no_replay", bus.rsp_valid, 2'b00);
      check_val("rr.no_wr",     bus.mem_write_en, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
